// File: rtl/nrisc_mul_seq_pkg.sv
// ----------------------------------------------------------------------------
// nrisc_mul_seq_pkg
// Shared constants for the multiply sequencer and its ULA-facing interface:
// default datapath width, ULA command encodings and ULA flag bit positions.
// ----------------------------------------------------------------------------
package nrisc_mul_seq_pkg;

   // Default operand / result / ULA width.
   localparam int TAM_DEFAULT = 32;

   // ULA commands: [3:1] selects the operation, [0] is the modifier.
   localparam logic [3:0] ULA_ADD = 4'b0000;
   localparam logic [3:0] ULA_SHL = 4'b1100;
   localparam logic [3:0] ULA_SHR = 4'b1000;

   // Bit positions inside ULA_flags = {minus, zero, carry}.
   localparam int FLAG_MINUS = 2;
   localparam int FLAG_ZERO  = 1;
   localparam int FLAG_CARRY = 0;

endpackage

// File: rtl/nrisc_mul_seq_if.sv
// ----------------------------------------------------------------------------
// nrisc_mul_seq_if
// Bundles the multiply request/response handshake and the ULA
// operand/command/result bus seen by the multiply sequencer.
//
//   mul_valid  requester -> seq   request strobe
//   mul_ready  seq -> requester   high while the sequencer is idle
//   mul_a/b    requester -> seq   operands, sampled on acceptance
//   mul_result seq -> requester   product mod 2^TAM, held until next accept
//   mul_done   seq -> requester   one-cycle pulse, mul_result valid with it
//   ULA_A/B    seq -> ULA         operands
//   ULA_ctrl   seq -> ULA         command
//   ULA_OUT    ULA -> seq         registered result (1-cycle latency)
//   ULA_flags  ULA -> seq         {minus, zero, carry}, registered with ULA_OUT
//
// Modports: slave is the sequencer's view; master is the surrounding
// environment (requester plus ULA).
// ----------------------------------------------------------------------------
interface nrisc_mul_seq_if
   import nrisc_mul_seq_pkg::*;
#(
   parameter int TAM = TAM_DEFAULT
);

   logic           mul_valid;
   logic           mul_ready;
   logic [TAM-1:0] mul_a;
   logic [TAM-1:0] mul_b;
   logic [TAM-1:0] mul_result;
   logic           mul_done;

   logic [TAM-1:0] ULA_A;
   logic [TAM-1:0] ULA_B;
   logic [3:0]     ULA_ctrl;
   logic [TAM-1:0] ULA_OUT;
   logic [2:0]     ULA_flags;

   modport slave (
      input  mul_valid, mul_a, mul_b, ULA_OUT, ULA_flags,
      output mul_ready, mul_result, mul_done, ULA_A, ULA_B, ULA_ctrl
   );

   modport master (
      output mul_valid, mul_a, mul_b, ULA_OUT, ULA_flags,
      input  mul_ready, mul_result, mul_done, ULA_A, ULA_B, ULA_ctrl
   );

endinterface

// File: rtl/nrisc_mul_seq.sv
// ----------------------------------------------------------------------------
// nrisc_mul_seq
// Multi-cycle unsigned shift-and-add multiplier that drives the shared ULA.
// Every arithmetic step (accumulate, shift multiplicand left, shift
// multiplier right) is issued to the ULA and its registered result is read
// back one cycle later, so each ULA op costs an issue (_I) and a wait (_W)
// cycle. The low TAM bits of the product are returned.
//
// Ports:
//   clk  rising-edge clock
//   rst  synchronous, active-high reset
//   bus  nrisc_mul_seq_if.slave: multiply handshake + ULA operand/command bus
// ----------------------------------------------------------------------------
module nrisc_mul_seq
   import nrisc_mul_seq_pkg::*;
#(
   parameter int TAM = TAM_DEFAULT
) (
   input  logic           clk,
   input  logic           rst,
   nrisc_mul_seq_if.slave bus
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_ADD_I,
      S_ADD_W,
      S_SHL_I,
      S_SHL_W,
      S_SHR_I,
      S_SHR_W,
      S_DONE
   } state_t;

   state_t         state;
   state_t         state_nxt;

   logic [TAM-1:0] acc;     // running partial product
   logic [TAM-1:0] mc;      // multiplicand, shifted left each iteration
   logic [TAM-1:0] mp;      // multiplier, shifted right each iteration
   logic [TAM-1:0] result;
   logic           done;

   logic           accept;
   logic [TAM-1:0] ula_a;
   logic [TAM-1:0] ula_b;
   logic [3:0]     ula_ctrl;

   assign accept = (state == S_IDLE) && bus.mul_valid;

   // -------------------------------------------------------------------------
   // Next-state logic.
   // -------------------------------------------------------------------------
   always_comb begin
      // NOTE: default first so every path assigns state_nxt; no latch.
      state_nxt = state;
      unique case (state)
         S_IDLE: begin
            if (bus.mul_valid) begin
               if (bus.mul_b == '0) begin
                  state_nxt = S_DONE;
               end else if (bus.mul_b[0]) begin
                  state_nxt = S_ADD_I;
               end else begin
                  state_nxt = S_SHL_I;
               end
            end
         end
         S_ADD_I: state_nxt = S_ADD_W;
         S_ADD_W: state_nxt = S_SHL_I;
         S_SHL_I: state_nxt = S_SHL_W;
         S_SHL_W: state_nxt = S_SHR_I;
         S_SHR_I: state_nxt = S_SHR_W;
         S_SHR_W: begin
            // The shifted multiplier is only visible on ULA_OUT this cycle;
            // its zero flag ends the loop, its LSB picks the next step.
            if (bus.ULA_flags[FLAG_ZERO]) begin
               state_nxt = S_DONE;
            end else if (bus.ULA_OUT[0]) begin
               state_nxt = S_ADD_I;
            end else begin
               state_nxt = S_SHL_I;
            end
         end
         S_DONE:  state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   // -------------------------------------------------------------------------
   // ULA drive: purely a function of state and registers, held for both the
   // issue and the wait cycle of each op.
   // -------------------------------------------------------------------------
   always_comb begin
      ula_a    = '0;
      ula_b    = '0;
      ula_ctrl = ULA_ADD;
      unique case (state)
         S_ADD_I, S_ADD_W: begin
            ula_a    = acc;
            ula_b    = mc;
            ula_ctrl = ULA_ADD;
         end
         S_SHL_I, S_SHL_W: begin
            ula_a    = mc;
            ula_b    = TAM'(1);
            ula_ctrl = ULA_SHL;
         end
         S_SHR_I, S_SHR_W: begin
            ula_a    = mp;
            ula_b    = TAM'(1);
            ula_ctrl = ULA_SHR;
         end
         default: begin
            ula_a    = '0;
            ula_b    = '0;
            ula_ctrl = ULA_ADD;
         end
      endcase
   end

   // -------------------------------------------------------------------------
   // State and datapath registers.
   // -------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      if (rst) begin
         state  <= S_IDLE;
         acc    <= '0;
         mc     <= '0;
         mp     <= '0;
         result <= '0;
         done   <= 1'b0;
      end else begin
         state <= state_nxt;
         done  <= 1'b0;
         unique case (state)
            S_IDLE: begin
               if (accept) begin
                  acc <= '0;
                  mc  <= bus.mul_a;
                  mp  <= bus.mul_b;
               end
            end
            S_ADD_W: acc <= bus.ULA_OUT;
            S_SHL_W: mc  <= bus.ULA_OUT;
            S_SHR_W: mp  <= bus.ULA_OUT;
            S_DONE: begin
               // Result and strobe are registered together, so mul_done
               // rises in the first IDLE cycle with mul_result already valid.
               result <= acc;
               done   <= 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign bus.mul_ready  = (state == S_IDLE);
   assign bus.mul_result = result;
   assign bus.mul_done   = done;
   assign bus.ULA_A      = ula_a;
   assign bus.ULA_B      = ula_b;
   assign bus.ULA_ctrl   = ula_ctrl;

endmodule

// File: tb/tb_nrisc_mul_seq.sv
// ----------------------------------------------------------------------------
// tb_nrisc_mul_seq
// Self-checking bench for nrisc_mul_seq. A behavioural ULA with one cycle of
// registered latency sits on the interface. Expected products come from
// plain wide multiplication, expected latencies from the bit pattern of the
// multiplier, and expected ULA command traces from the list of operations
// the shift-and-add algorithm performs per multiplier bit.
// ----------------------------------------------------------------------------
module tb_nrisc_mul_seq;
   import nrisc_mul_seq_pkg::*;

   localparam int W = 32;

   logic clk = 1'b0;
   logic rst = 1'b1;

   int n_checks = 0;
   int n_pass   = 0;

   logic [3:0]   trace_ctrl[$];
   logic [W-1:0] trace_ab[$];

   nrisc_mul_seq_if #(.TAM(W)) bus ();

   nrisc_mul_seq #(.TAM(W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   // ---------------------------------------------------------------- ULA
   function automatic logic [W:0] ula_eval(input logic [W-1:0] a,
                                           input logic [W-1:0] b,
                                           input logic [3:0]   ctrl);
      case (ctrl[3:1])
         3'b000:  return {1'b0, a} + {1'b0, b};
         3'b110:  return {1'b0, a << b[4:0]};
         3'b100:  return {1'b0, a >> b[4:0]};
         default: return '0;
      endcase
   endfunction

   logic [W:0] ula_next;
   assign ula_next = ula_eval(bus.ULA_A, bus.ULA_B, bus.ULA_ctrl);

   always_ff @(posedge clk) begin
      bus.ULA_OUT   <= ula_next[W-1:0];
      bus.ULA_flags <= {ula_next[W-1], (ula_next[W-1:0] == '0), ula_next[W]};
   end

   // ---------------------------------------------------------- reference
   function automatic logic [W-1:0] ref_product(input logic [W-1:0] a,
                                                input logic [W-1:0] b);
      logic [2*W-1:0] p;
      p = {{W{1'b0}}, a} * {{W{1'b0}}, b};
      return p[W-1:0];
   endfunction

   // Edges from acceptance to the edge that starts the mul_done cycle.
   function automatic int ref_latency(input logic [W-1:0] b);
      int msb = -1;
      int lat = 1;
      for (int i = 0; i < W; i++) if (b[i]) msb = i;
      for (int i = 0; i <= msb; i++) lat += b[i] ? 6 : 4;
      return lat;
   endfunction

   // ------------------------------------------------------------ driver
   // Issues one request, then records ULA_ctrl and ULA_A|ULA_B every cycle
   // until mul_done. lat = edges from acceptance to the mul_done cycle.
   task automatic run_mul(input logic [W-1:0] a, input logic [W-1:0] b,
                          output logic [W-1:0] res, output int lat);
      int guard = 0;
      @(negedge clk);
      while (!bus.mul_ready && guard < 500) begin
         @(negedge clk);
         guard++;
      end
      bus.mul_valid = 1'b1;
      bus.mul_a     = a;
      bus.mul_b     = b;
      @(posedge clk);
      @(negedge clk);
      bus.mul_valid = 1'b0;
      bus.mul_a     = $urandom;
      bus.mul_b     = $urandom;
      trace_ctrl.delete();
      trace_ab.delete();
      lat = 0;
      while (!bus.mul_done && lat < 1000) begin
         trace_ctrl.push_back(bus.ULA_ctrl);
         trace_ab.push_back(bus.ULA_A | bus.ULA_B);
         @(posedge clk);
         lat++;
         @(negedge clk);
      end
      if (!bus.mul_done) lat = -1;
      res = bus.mul_result;
   endtask

   // -------------------------------------------------------------- tests
   task automatic test_reset();
      rst           = 1'b1;
      bus.mul_valid = 1'b0;
      bus.mul_a     = '0;
      bus.mul_b     = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      n_checks++; if (bus.mul_ready !== 1'b1) $display("FAIL reset_ready: got %b want 1", bus.mul_ready); else n_pass++;
      n_checks++; if (bus.mul_done !== 1'b0) $display("FAIL reset_done: got %b want 0", bus.mul_done); else n_pass++;
      n_checks++; if (bus.mul_result !== '0) $display("FAIL reset_result: got %h want 0", bus.mul_result); else n_pass++;
      n_checks++; if (bus.ULA_ctrl !== 4'b0000) $display("FAIL reset_ctrl: got %b want 0000", bus.ULA_ctrl); else n_pass++;
      n_checks++; if (bus.ULA_A !== '0 || bus.ULA_B !== '0)
         $display("FAIL reset_ula_ab: got A=%h B=%h want 0/0", bus.ULA_A, bus.ULA_B); else n_pass++;
      rst = 1'b0;
   endtask

   task automatic test_basic();
      logic [W-1:0] res;
      int           lat;
      logic [3:0]   exp_tr[$];
      logic [W-1:0] b = 5;
      int           bad = -1;
      run_mul(3, b, res, lat);
      n_checks++; if (res !== 32'd15) $display("FAIL basic_result: got %0d want 15", res); else n_pass++;
      n_checks++; if (lat !== 17) $display("FAIL basic_latency: got %0d want 17", lat); else n_pass++;
      // Per multiplier bit: accumulate if set, then shift both operands.
      for (int i = 0; i < 3; i++) begin
         if (b[i]) begin exp_tr.push_back(ULA_ADD); exp_tr.push_back(ULA_ADD); end
         exp_tr.push_back(ULA_SHL); exp_tr.push_back(ULA_SHL);
         exp_tr.push_back(ULA_SHR); exp_tr.push_back(ULA_SHR);
      end
      exp_tr.push_back(4'b0000);
      n_checks++; if (trace_ctrl.size() !== exp_tr.size())
         $display("FAIL basic_trace_len: got %0d want %0d", trace_ctrl.size(), exp_tr.size()); else n_pass++;
      for (int i = 0; i < exp_tr.size() && i < trace_ctrl.size(); i++)
         if (bad < 0 && trace_ctrl[i] !== exp_tr[i]) bad = i;
      n_checks++; if (bad >= 0)
         $display("FAIL basic_cmd_trace: cycle %0d got %b want %b", bad, trace_ctrl[bad], exp_tr[bad]); else n_pass++;
      @(posedge clk);
      @(negedge clk);
      n_checks++; if (bus.mul_done !== 1'b0) $display("FAIL done_pulse_width: got %b want 0", bus.mul_done); else n_pass++;
      n_checks++; if (bus.mul_result !== 32'd15) $display("FAIL result_hold: got %0d want 15", bus.mul_result); else n_pass++;
   endtask

   task automatic test_zero_multiplier();
      logic [W-1:0] res;
      int           lat;
      run_mul(32'h1234, 0, res, lat);
      n_checks++; if (res !== '0) $display("FAIL zero_result: got %h want 0", res); else n_pass++;
      n_checks++; if (lat !== 1) $display("FAIL zero_latency: got %0d want 1", lat); else n_pass++;
      n_checks++; if (trace_ctrl.size() != 1 || trace_ctrl[0] !== 4'b0000 || trace_ab[0] !== '0)
         $display("FAIL zero_no_ula_cmd: got %0d cycles, first ctrl=%b ab=%h want 1 cycle ctrl=0000 ab=0",
                  trace_ctrl.size(), trace_ctrl[0], trace_ab[0]); else n_pass++;
   endtask

   task automatic test_wrap();
      logic [W-1:0] res;
      int           lat;
      run_mul(32'hFFFF_FFFF, 32'hFFFF_FFFF, res, lat);
      n_checks++; if (res !== 32'h0000_0001) $display("FAIL wrap_result: got %h want 00000001", res); else n_pass++;
      n_checks++; if (lat !== 193) $display("FAIL wrap_latency: got %0d want 193", lat); else n_pass++;
   endtask

   task automatic test_random();
      logic [W-1:0] a, b, res;
      int           lat;
      for (int n = 0; n < 16; n++) begin
         a = (n == 0) ? '0 : W'($urandom);
         b = W'($urandom) >> $urandom_range(0, 31);
         if (n == 0 && b == '0) b = 32'h0000_00A5;
         run_mul(a, b, res, lat);
         n_checks++; if (res !== ref_product(a, b))
            $display("FAIL rand_result[%0d]: %h*%h got %h want %h", n, a, b, res, ref_product(a, b)); else n_pass++;
         n_checks++; if (lat !== ref_latency(b))
            $display("FAIL rand_latency[%0d]: b=%h got %0d want %0d", n, b, lat, ref_latency(b)); else n_pass++;
      end
   endtask

   task automatic test_busy();
      int k = 0;
      int ready_bad = 0;
      int k2 = 0;
      @(negedge clk);
      while (!bus.mul_ready && k < 500) begin @(negedge clk); k++; end
      k = 0;
      bus.mul_valid = 1'b1;
      bus.mul_a     = 3;
      bus.mul_b     = 5;
      @(posedge clk);
      @(negedge clk);
      // A second request is held for the whole busy period.
      bus.mul_a = 7;
      bus.mul_b = 7;
      while (!bus.mul_done && k < 1000) begin
         if (bus.mul_ready !== 1'b0) ready_bad++;
         @(posedge clk);
         k++;
         @(negedge clk);
      end
      n_checks++; if (ready_bad != 0) $display("FAIL busy_ready_low: got %0d cycles ready=1 want 0", ready_bad); else n_pass++;
      n_checks++; if (k !== 17) $display("FAIL busy_first_latency: got %0d want 17", k); else n_pass++;
      n_checks++; if (bus.mul_result !== 32'd15) $display("FAIL busy_first_result: got %0d want 15", bus.mul_result); else n_pass++;
      n_checks++; if (bus.mul_ready !== 1'b1) $display("FAIL busy_ready_after_done: got %b want 1", bus.mul_ready); else n_pass++;
      @(posedge clk);
      @(negedge clk);
      bus.mul_valid = 1'b0;
      n_checks++; if (bus.mul_ready !== 1'b0) $display("FAIL b2b_accepted: ready got %b want 0", bus.mul_ready); else n_pass++;
      while (!bus.mul_done && k2 < 1000) begin
         @(posedge clk);
         k2++;
         @(negedge clk);
      end
      n_checks++; if (k2 !== ref_latency(7)) $display("FAIL b2b_latency: got %0d want %0d", k2, ref_latency(7)); else n_pass++;
      n_checks++; if (bus.mul_result !== ref_product(7, 7))
         $display("FAIL b2b_result: got %0d want %0d", bus.mul_result, ref_product(7, 7)); else n_pass++;
   endtask

   task automatic test_reset_mid();
      int pulses = 0;
      logic [W-1:0] res;
      int           lat;
      @(negedge clk);
      bus.mul_valid = 1'b1;
      bus.mul_a     = 3;
      bus.mul_b     = 5;
      @(posedge clk);
      @(negedge clk);
      bus.mul_valid = 1'b0;
      // Acceptance edge was edge 0; after edge 3 the multiply is in SHL_W.
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      n_checks++; if (bus.mul_ready !== 1'b1) $display("FAIL midrst_ready: got %b want 1", bus.mul_ready); else n_pass++;
      n_checks++; if (bus.mul_result !== '0) $display("FAIL midrst_result: got %h want 0", bus.mul_result); else n_pass++;
      n_checks++; if (bus.ULA_ctrl !== 4'b0000 || bus.ULA_A !== '0)
         $display("FAIL midrst_ula: got ctrl=%b A=%h want 0000/0", bus.ULA_ctrl, bus.ULA_A); else n_pass++;
      for (int i = 0; i < 30; i++) begin
         if (bus.mul_done !== 1'b0) pulses++;
         @(negedge clk);
      end
      n_checks++; if (pulses != 0) $display("FAIL midrst_no_done: got %0d done cycles want 0", pulses); else n_pass++;
      run_mul(6, 7, res, lat);
      n_checks++; if (res !== 32'd42) $display("FAIL midrst_recover: got %0d want 42", res); else n_pass++;
   endtask

   initial begin
      bus.mul_valid = 1'b0;
      bus.mul_a     = '0;
      bus.mul_b     = '0;
      test_reset();
      test_basic();
      test_zero_multiplier();
      test_wrap();
      test_random();
      test_busy();
      test_reset_mid();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached after %0d/%0d checks", n_pass, n_checks);
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/nrisc_mul_seq.md
# nrisc_mul_seq

Multi-cycle unsigned multiplier sequencer that acts as the initiator on the ULA operand/command interface. It accepts a TAM×TAM multiply request and executes shift-and-add using only ULA operations: ADD, SHL and SHR. It reads back ULA_OUT and the ULA zero flag, and returns the low TAM bits of the product. It sits beside the ULA in the execute stage and owns the ULA's inputs while busy.

## Interface
- TAM, default `TAM (32): operand, result and ULA width.

- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- mul_valid  in  1  request strobe; accepted when mul_valid & mul_ready at a rising edge.
- mul_ready  out  1  high only in IDLE.
- mul_a  in  TAM  multiplicand; sampled on acceptance.
- mul_b  in  TAM  multiplier; sampled on acceptance.
- mul_result  out  TAM  product mod 2^TAM; held until the next acceptance.
- mul_done  out  1  one-cycle pulse; mul_result is valid in the same cycle.
- ULA_A  out  TAM  ULA operand A.
- ULA_B  out  TAM  ULA operand B.
- ULA_ctrl  out  4  ULA command: [3:1] selects the operation, [0] is the modifier.
- ULA_OUT  in  TAM  ULA result, registered inside the ULA (1-cycle latency).
- ULA_flags  in  3  {minus, zero, carry}, registered together with ULA_OUT.

## Operation
- Internal registers:
  - acc: accumulator.
  - mc: multiplicand.
  - mp: multiplier.
- States: IDLE, ADD_I, ADD_W, SHL_I, SHL_W, SHR_I, SHR_W, DONE.
- ULA commands:
  - ADD = 4'b0000.
  - SHL = 4'b1100.
  - SHR = 4'b1000, logical, amount taken from ULA_B[4:0].
- ULA outputs are combinational from state and registers:
  - ADD_I / ADD_W: A=acc, B=mc, ctrl=ADD.
  - SHL_I / SHL_W: A=mc, B=1, ctrl=SHL.
  - SHR_I / SHR_W: A=mp, B=1, ctrl=SHR.
  - All other states: A=0, B=0, ctrl=4'b0000.
- Acceptance in IDLE:
  - Load acc=0, mc=mul_a, mp=mul_b.
  - If mul_b==0, go to DONE.
  - Else if mul_b[0]=1, go to ADD_I; otherwise go to SHL_I.
- Fixed transitions:
  - ADD_I→ADD_W; at the end of ADD_W, acc←ULA_OUT, then →SHL_I.
  - SHL_I→SHL_W; at the end of SHL_W, mc←ULA_OUT, then →SHR_I.
  - SHR_I→SHR_W; at the end of SHR_W, mp←ULA_OUT.
- Exit from SHR_W:
  - If ULA_flags[1] (zero) = 1, go to DONE.
  - Else if ULA_OUT[0]=1, go to ADD_I; otherwise go to SHL_I.
- DONE: mul_result←acc, mul_done=1, then →IDLE unconditionally.
- Arithmetic:
  - Product is modulo 2^TAM; overflow is not reported.
  - Bits of mc shifted past the MSB are discarded.
  - ULA carry and minus flags are ignored.
- mul_valid outside IDLE is ignored; no queuing.
- mul_a = 0 with mul_b ≠ 0 runs the full loop (no shortcut) and yields 0.

## Timing
- Reset values (on the edge where rst=1, from any state):
  - state=IDLE, acc=mc=mp=0, mul_result=0.
  - mul_done=0, mul_ready=1.
  - ULA_A=0, ULA_B=0, ULA_ctrl=4'b0000.
- Reset mid-operation abandons the multiply with no mul_done; the ULA's internal register is not touched.
- Each ULA op takes 2 cycles: inputs are stable during the _I cycle, the ULA registers at the end of _I, and the sequencer captures at the end of _W.
- Iteration cost: 6 cycles for a multiplier bit of 1, 4 cycles for a bit of 0.
- Latency: mul_done is high in the cycle beginning 6·n1 + 4·n0 + 1 edges after the acceptance edge.
  - n1 / n0 are the counts of one / zero bits of mul_b from bit 0 up to its highest set bit.
  - mul_b = 0: mul_done is high in the cycle right after acceptance.
- mul_ready deasserts the cycle after acceptance and reasserts the cycle after DONE.
- Back-to-back: a request held during DONE is accepted on the first IDLE edge.

## Structure
- Add to const.v:
  - ULA command constants: ULA_ADD = 4'b0000, ULA_SHL = 4'b1100, ULA_SHR = 4'b1000.
  - Flag index constants: FLAG_MINUS = 2, FLAG_ZERO = 1, FLAG_CARRY = 0.
  - State encoding localparams stay local to the module.
- Single module, no sub-module. The ULA is instantiated alongside it in the datapath and in the testbench, not inside this block.

## Test plan
- Reset: rst high for 2 cycles → mul_ready=1, mul_done=0, mul_result=0, ULA_ctrl=4'b0000, ULA_A=ULA_B=0.
- Basic multiply, mul_a=3, mul_b=5 with the ULA connected → mul_done at acceptance+17 edges, mul_result=15; sequence is ADD,SHL,SHR,SHL,SHR,ADD,SHL,SHR.
- Zero multiplier, mul_a=0x1234, mul_b=0 → mul_done the cycle after acceptance, mul_result=0, no ULA command issued.
- Full-width wrap (TAM=32), 0xFFFFFFFF × 0xFFFFFFFF → mul_result=0x00000001, mul_done at acceptance+193.
- Busy handling: second mul_valid (a=7, b=7) held during a busy multiply → mul_ready=0 and the request is ignored; it is accepted on the first IDLE edge and yields 49.
- Reset mid-operation: rst asserted in SHL_W of a 3×5 multiply → next cycle IDLE, mul_ready=1, mul_result=0, no mul_done pulse.
